rs_alu: RTL and testbench

Reservation station for the integer ALU in the out-of-order core. Sits between dispatch/rename and `fu_alu`, buffering renamed ALU micro-ops until both physical source operands are ready. Ready operands are tracked by snooping writeback tags. Each cycle the oldest ready entry is selected and issued to `fu_alu` whenever `fu_alu_ready` is high.

---
 rtl/rs_alu_pkg.sv | 31 +++
 rtl/rs_alu_if.sv | 31 +++
 rtl/rs_wakeup_cmp.sv | 22 ++
 rtl/rs_alu.sv | 141 ++++++++++++++
 tb/tb_rs_alu.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_alu_pkg.sv
// rs_alu_pkg: shared types for the ALU reservation station.
// Holds sizing constants, the renamed-op bundle and the entry layout.
package rs_alu_pkg;

    localparam int RS_ALU_DEPTH = 8;
    localparam int RS_PREG_W    = 7;
    localparam int RS_ROB_W     = 5;
    localparam int RS_N_WB      = 3;

    localparam logic [1:0] FU_ALU = 2'd1;

    typedef struct packed {
        logic                 valid;
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic [6:0]           func7;
        logic [31:0]          imm;
        logic [RS_PREG_W-1:0] pd;
        logic [RS_PREG_W-1:0] ps1;
        logic [RS_PREG_W-1:0] ps2;
        logic [RS_ROB_W-1:0]  rob_index;
        logic [1:0]           fu;
    } rs_data;

    typedef struct packed {
        rs_data data;
        logic   rdy1;
        logic   rdy2;
    } rs_alu_entry;

endpackage

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, wakeup broadcast and issue signals of rs_alu.
// master = dispatch/writeback/fu_alu side, slave = reservation station.
interface rs_alu_if
    import rs_alu_pkg::*;
#(
    parameter int N_WB   = RS_N_WB,
    parameter int PREG_W = RS_PREG_W
);
    logic                   disp_valid;
    rs_data                 disp_data;
    logic                   disp_ps1_rdy;
    logic                   disp_ps2_rdy;
    logic                   rs_full;
    logic [N_WB-1:0]        wb_valid;
    logic [N_WB*PREG_W-1:0] wb_pd;
    logic                   fu_alu_ready;
    logic                   issued;
    rs_data                 issue_data;

    modport master (
        output disp_valid, disp_data, disp_ps1_rdy, disp_ps2_rdy,
        output wb_valid, wb_pd, fu_alu_ready,
        input  rs_full, issued, issue_data
    );

    modport slave (
        input  disp_valid, disp_data, disp_ps1_rdy, disp_ps2_rdy,
        input  wb_valid, wb_pd, fu_alu_ready,
        output rs_full, issued, issue_data
    );
endinterface

// File: rtl/rs_wakeup_cmp.sv
// rs_wakeup_cmp: matches one physical tag against all writeback ports.
// Ports: i_tag, i_wb_valid[N_WB], i_wb_pd[N_WB*PREG_W] -> o_hit.
module rs_wakeup_cmp
    import rs_alu_pkg::*;
#(
    parameter int N_WB   = RS_N_WB,
    parameter int PREG_W = RS_PREG_W
) (
    input  logic [PREG_W-1:0]      i_tag,
    input  logic [N_WB-1:0]        i_wb_valid,
    input  logic [N_WB*PREG_W-1:0] i_wb_pd,
    output logic                   o_hit
);
    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < N_WB; i++) begin
            if (i_wb_valid[i] && (i_wb_pd[i*PREG_W +: PREG_W] == i_tag)) begin
                o_hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_alu.sv
// rs_alu: collapsing-queue reservation station feeding fu_alu.
// Ports: i_clk, i_reset (sync, high), i_flush, io (rs_alu_if.slave).
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int DEPTH  = RS_ALU_DEPTH,
    parameter int PREG_W = RS_PREG_W,
    parameter int N_WB   = RS_N_WB
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_flush,
    rs_alu_if.slave io
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_alu_entry     r_ent [DEPTH];
    logic [CW-1:0]   r_count;

    logic [DEPTH-1:0] w_wk1;
    logic [DEPTH-1:0] w_wk2;
    logic [DEPTH-1:0] w_rdy;
    logic             w_d1;
    logic             w_d2;
    logic             w_sel_vld;
    logic [IW-1:0]    w_sel;
    logic             w_issue;
    logic             w_full;
    logic             w_accept;
    rs_alu_entry      w_new;
    rs_alu_entry      w_wok [DEPTH];
    rs_alu_entry      w_nxt [DEPTH];
    logic [CW-1:0]    w_cnt_after;
    logic [CW-1:0]    w_cnt_nxt;

    // Per-entry wakeup comparators on both source tags.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        rs_wakeup_cmp #(.N_WB(N_WB), .PREG_W(PREG_W)) u_cmp1 (
            .i_tag      (r_ent[g].data.ps1),
            .i_wb_valid (io.wb_valid),
            .i_wb_pd    (io.wb_pd),
            .o_hit      (w_wk1[g])
        );
        rs_wakeup_cmp #(.N_WB(N_WB), .PREG_W(PREG_W)) u_cmp2 (
            .i_tag      (r_ent[g].data.ps2),
            .i_wb_valid (io.wb_valid),
            .i_wb_pd    (io.wb_pd),
            .o_hit      (w_wk2[g])
        );
        // Select sees registered ready bits only: no same-cycle bypass.
        assign w_rdy[g] = (CW'(g) < r_count)
                        && r_ent[g].rdy1 && r_ent[g].rdy2;
    end

    // Dispatch operands can be woken by a same-cycle broadcast.
    rs_wakeup_cmp #(.N_WB(N_WB), .PREG_W(PREG_W)) u_dcmp1 (
        .i_tag      (io.disp_data.ps1),
        .i_wb_valid (io.wb_valid),
        .i_wb_pd    (io.wb_pd),
        .o_hit      (w_d1)
    );
    rs_wakeup_cmp #(.N_WB(N_WB), .PREG_W(PREG_W)) u_dcmp2 (
        .i_tag      (io.disp_data.ps2),
        .i_wb_valid (io.wb_valid),
        .i_wb_pd    (io.wb_pd),
        .o_hit      (w_d2)
    );

    // Priority encoder: lowest index (oldest) ready entry wins.
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_sel_vld = 1'b1;
                w_sel     = IW'(i);
            end
        end
    end

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_issue  = io.fu_alu_ready && w_sel_vld;
    assign w_accept = io.disp_valid && !w_full;

    assign io.rs_full    = w_full;
    assign io.issued     = w_issue;
    assign io.issue_data = w_issue ? r_ent[w_sel].data : '0;

    always_comb begin
        w_new            = '0;
        w_new.data       = io.disp_data;
        w_new.data.valid = 1'b1;
        w_new.rdy1       = io.disp_ps1_rdy || (io.disp_data.ps1 == '0) || w_d1;
        w_new.rdy2       = io.disp_ps2_rdy || (io.disp_data.ps2 == '0) || w_d2;
    end

    // Wakeup, then collapse above the issued slot, then append.
    always_comb begin
        w_cnt_after = r_count - CW'(w_issue);
        for (int i = 0; i < DEPTH; i++) begin
            w_wok[i]      = r_ent[i];
            w_wok[i].rdy1 = r_ent[i].rdy1 || w_wk1[i];
            w_wok[i].rdy2 = r_ent[i].rdy2 || w_wk2[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_issue && (IW'(i) >= w_sel)) begin
                w_nxt[i] = w_wok[i+1];
            end else begin
                w_nxt[i] = w_wok[i];
            end
        end
        if (w_issue) begin
            w_nxt[DEPTH-1] = '0;
        end else begin
            w_nxt[DEPTH-1] = w_wok[DEPTH-1];
        end
        if (w_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_cnt_after) begin
                    w_nxt[i] = w_new;
                end
            end
        end
        w_cnt_nxt = w_cnt_after + CW'(w_accept);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_count <= w_cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_nxt[i];
            end
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed bench for rs_alu with a queue-based reference model.
// The model is checked every cycle; literal expectations pin key points.
module tb_rs_alu;
    import rs_alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 7;
    localparam int NW    = 3;

    typedef struct {
        rs_data d;
        bit     r1;
        bit     r2;
    } ment_t;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;
    ment_t mq[$];

    rs_alu_if #(.N_WB(NW), .PREG_W(PW)) intf ();

    rs_alu #(.DEPTH(DEPTH), .PREG_W(PW), .N_WB(NW)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (flush),
        .io      (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit hit(logic [PW-1:0] t);
        for (int k = 0; k < NW; k++) begin
            if (intf.wb_valid[k] && intf.wb_pd[k*PW +: PW] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int first_rdy();
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].r1 && mq[k].r2) return k;
        end
        return -1;
    endfunction

    // Reference model: queue in age order, updated at each edge.
    always @(posedge clk) begin : model
        ment_t nq[$];
        ment_t ne;
        int    ix;
        int    sz;
        if (reset || flush) begin
            mq.delete();
        end else begin
            sz = mq.size();
            ix = first_rdy();
            nq = mq;
            if (intf.fu_alu_ready && ix >= 0) nq.delete(ix);
            for (int k = 0; k < nq.size(); k++) begin
                if (hit(nq[k].d.ps1)) nq[k].r1 = 1'b1;
                if (hit(nq[k].d.ps2)) nq[k].r2 = 1'b1;
            end
            if (intf.disp_valid && sz < DEPTH) begin
                ne.d       = intf.disp_data;
                ne.d.valid = 1'b1;
                ne.r1 = intf.disp_ps1_rdy || intf.disp_data.ps1 == 0
                        || hit(intf.disp_data.ps1);
                ne.r2 = intf.disp_ps2_rdy || intf.disp_data.ps2 == 0
                        || hit(intf.disp_data.ps2);
                nq.push_back(ne);
            end
            mq = nq;
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin : compare
        int     ix;
        logic   ei;
        rs_data ed;
        if (!reset) begin
            ix = first_rdy();
            ei = intf.fu_alu_ready && (ix >= 0);
            ed = ei ? mq[ix].d : '0;
            chk("m_issued", 128'(intf.issued), 128'(ei));
            chk("m_issue_data", 128'(intf.issue_data), 128'(ed));
            chk("m_rs_full", 128'(intf.rs_full), 128'(mq.size() == DEPTH));
            chk("m_count", 128'(dut.r_count), 128'(mq.size()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        intf.disp_valid = 1'b0;
        intf.wb_valid   = '0;
        flush           = 1'b0;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic disp(int rob, int pd, int ps1, bit r1, int ps2, bit r2);
        intf.disp_valid           = 1'b1;
        intf.disp_data            = '0;
        intf.disp_data.opcode     = 7'h13;
        intf.disp_data.imm        = 32'(rob * 3 + 1);
        intf.disp_data.pd         = PW'(pd);
        intf.disp_data.ps1        = PW'(ps1);
        intf.disp_data.ps2        = PW'(ps2);
        intf.disp_data.rob_index  = RS_ROB_W'(rob);
        intf.disp_data.fu         = FU_ALU;
        intf.disp_ps1_rdy         = r1;
        intf.disp_ps2_rdy         = r2;
    endtask

    task automatic wb(int port, int tag);
        intf.wb_valid[port]          = 1'b1;
        intf.wb_pd[port*PW +: PW]    = PW'(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        intf.disp_valid   = 1'b0;
        intf.disp_data    = '0;
        intf.disp_ps1_rdy = 1'b0;
        intf.disp_ps2_rdy = 1'b0;
        intf.wb_valid     = '0;
        intf.wb_pd        = '0;
        intf.fu_alu_ready = 1'b1;

        repeat (5) tick();
        neg();
        chk("rst_issued", 128'(intf.issued), 128'd0);
        chk("rst_issue_data", 128'(intf.issue_data), 128'd0);
        chk("rst_full", 128'(intf.rs_full), 128'd0);
        tick();
        reset = 1'b0;

        // ADDI, both ready: issues one cycle after the accepting edge.
        disp(3, 5, 12, 1, 0, 0);
        neg();
        chk("addi_pre", 128'(intf.issued), 128'd0);
        tick();
        neg();
        chk("addi_iss", 128'(intf.issued), 128'd1);
        chk("addi_pd", 128'(intf.issue_data.pd), 128'd5);
        chk("addi_rob", 128'(intf.issue_data.rob_index), 128'd3);
        chk("addi_vld", 128'(intf.issue_data.valid), 128'd1);
        tick();
        neg();
        chk("addi_cnt", 128'(dut.r_count), 128'd0);

        // SUB waits on ps1=20, woken by port 1.
        tick();
        disp(4, 6, 20, 0, 21, 1);
        intf.disp_data.opcode = 7'h33;
        intf.disp_data.func7  = 7'h20;
        tick();
        neg();
        chk("sub_wait", 128'(intf.issued), 128'd0);
        tick();
        wb(1, 20);
        neg();
        chk("sub_nobyp", 128'(intf.issued), 128'd0);
        tick();
        neg();
        chk("sub_iss", 128'(intf.issued), 128'd1);
        chk("sub_rob", 128'(intf.issue_data.rob_index), 128'd4);
        tick();

        // A blocked, B and C ready: B, C issue around A.
        disp(10, 30, 30, 0, 0, 0);
        tick();
        disp(11, 31, 1, 1, 2, 1);
        tick();
        disp(12, 32, 3, 1, 4, 1);
        neg();
        chk("b_rob", 128'(intf.issue_data.rob_index), 128'd11);
        tick();
        neg();
        chk("c_rob", 128'(intf.issue_data.rob_index), 128'd12);
        tick();
        neg();
        chk("a_wait", 128'(intf.issued), 128'd0);
        chk("a_head", 128'(dut.r_ent[0].data.rob_index), 128'd10);
        tick();
        wb(0, 30);
        tick();
        neg();
        chk("a_rob", 128'(intf.issue_data.rob_index), 128'd10);
        tick();

        // Fill to DEPTH with the ALU stalled.
        intf.fu_alu_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            disp(k, 40 + k, 0, 1, 0, 1);
            tick();
        end
        neg();
        chk("fill_full", 128'(intf.rs_full), 128'd1);
        tick();
        disp(20, 60, 0, 1, 0, 1);
        tick();
        neg();
        chk("fill_cnt9", 128'(dut.r_count), 128'd8);
        tick();
        intf.fu_alu_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            neg();
            chk("drain_rob", 128'(intf.issue_data.rob_index), 128'(k));
            chk("drain_full", 128'(intf.rs_full), 128'(k == 0));
            tick();
        end
        neg();
        chk("drain_empty", 128'(intf.issued), 128'd0);

        // Same-cycle broadcast on port 2 captures ps1 as ready.
        tick();
        disp(5, 9, 40, 0, 0, 0);
        wb(2, 40);
        tick();
        neg();
        chk("byp_iss", 128'(intf.issued), 128'd1);
        chk("byp_rob", 128'(intf.issue_data.rob_index), 128'd5);
        tick();

        // Flush with four entries and a dispatch in flight.
        intf.fu_alu_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(20 + k, 50 + k, 0, 1, 0, 1);
            tick();
        end
        neg();
        chk("fl_cnt4", 128'(dut.r_count), 128'd4);
        tick();
        flush = 1'b1;
        intf.fu_alu_ready = 1'b1;
        disp(24, 58, 0, 1, 0, 1);
        neg();
        chk("fl_iss_rob", 128'(intf.issue_data.rob_index), 128'd20);
        tick();
        neg();
        chk("fl_cnt", 128'(dut.r_count), 128'd0);
        chk("fl_issued", 128'(intf.issued), 128'd0);
        chk("fl_full", 128'(intf.rs_full), 128'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
